// File: rtl/mem_arbiter.sv
// mem_arbiter: two-core round-robin arbiter onto a single fixed-latency memory port.
module mem_arbiter #(
  parameter int WIDTH = 32,
  parameter int LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic             we0,
  input  logic             we1,
  input  logic [WIDTH-1:0] addr0,
  input  logic [WIDTH-1:0] addr1,
  input  logic [WIDTH-1:0] wd0,
  input  logic [WIDTH-1:0] wd1,
  output logic [WIDTH-1:0] rd0,
  output logic [WIDTH-1:0] rd1,
  output logic             ready0,
  output logic             ready1,
  output logic [1:0]       grant,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wd,
  input  logic [WIDTH-1:0] mem_rd
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_n;
  logic [3:0] cnt;
  logic last, win, lat_we, accept, done;
  assign accept = (state == IDLE) && (req0 || req1);
  // on a tie the core that was not served last wins; otherwise the lone requester
  assign win = (req0 && req1) ? ~last : req1;
  assign done = (state == BUSY) && (cnt == 4'd0);
  always_ff @(posedge clk)
    if (reset) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE) ? (accept ? BUSY : IDLE) :
              (state == BUSY) ? (done ? RESP : BUSY) : IDLE;
    mem_en = (state == BUSY);
    mem_we = mem_en && lat_we;
    ready0 = (state == RESP) && grant[0];
    ready1 = (state == RESP) && grant[1];
  end
  always_ff @(posedge clk)
    if (reset) begin
      grant <= 2'b00;
      cnt <= 4'd0;
      last <= 1'b1;
      lat_we <= 1'b0;
      mem_addr <= '0;
      mem_wd <= '0;
      rd0 <= '0;
      rd1 <= '0;
    end else begin
      if (accept) begin
        grant <= win ? 2'b10 : 2'b01;
        last <= win;
        cnt <= 4'(LAT - 1);
        lat_we <= win ? we1 : we0;
        mem_addr <= win ? addr1 : addr0;
        mem_wd <= win ? wd1 : wd0;
      end
      if (state == BUSY) cnt <= done ? 4'd0 : cnt - 4'd1;
      if (done && !lat_we && grant[0]) rd0 <= mem_rd;
      if (done && !lat_we && grant[1]) rd1 <= mem_rd;
      if (state == RESP) grant <= 2'b00;
    end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WIDTH, 32, data and address width of every request and memory bus.
REQ-002 Parameter: LAT, 2, memory access latency in cycles, legal range 1..15.
REQ-003 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk edge.
REQ-005 Port: req0, req1  input  1 each  access request from core 0 / core 1.
REQ-006 Port: we0, we1  input  1 each  write enable qualifying req0 / req1.
REQ-007 Port: addr0, addr1  input  WIDTH each  request address.
REQ-008 Port: wd0, wd1  input  WIDTH each  request write data.
REQ-009 Port: rd0, rd1  output  WIDTH each  read data returned to core 0 / core 1.
REQ-010 Port: ready0, ready1  output  1 each  one-cycle completion pulse to core 0 / core 1.
REQ-011 Port: grant  output  2  one-hot owner of the memory port; 2'b00 when idle.
REQ-012 Port: mem_en, mem_we  output  1 each  memory access strobe and write enable.
REQ-013 Port: mem_addr, mem_wd  output  WIDTH each  memory address and write data.
REQ-014 Port: mem_rd  input  WIDTH  memory read data, valid in the last cycle of mem_en.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-016 In IDLE, if req0 or req1 is high, the block SHALL latch the winner's we/addr/wd, set grant, load counter with LAT-1, and enter BUSY.
REQ-017 Single request: the requester SHALL win regardless of history.
REQ-018 Both requests: the core not named in register last (last granted core) SHALL win; last SHALL update to the winner on every acceptance.
REQ-019 In BUSY, mem_en SHALL be 1 and mem_we/mem_addr/mem_wd SHALL equal the latched values, stable, for exactly LAT consecutive cycles.
REQ-020 The counter SHALL decrement each BUSY cycle; at count 0 the block SHALL register mem_rd into the winner's rd output (reads only) and enter RESP.
REQ-021 In RESP, the winner's ready SHALL be 1 for exactly one cycle, mem_en SHALL be 0, then the FSM SHALL return to IDLE.
REQ-022 Timing: req accepted in IDLE cycle k -> mem_en high cycles k+1..k+LAT -> ready high cycle k+LAT+1 -> IDLE cycle k+LAT+2.
REQ-023 On a write, rd of the winner SHALL hold its previous value; the loser's rd SHALL never change.
REQ-024 Requests arriving in BUSY or RESP SHALL be ignored until IDLE; no request is lost if held.
REQ-025 A requester SHALL drop req on the edge ending its ready cycle; a req still high in the following IDLE cycle is a new request.
REQ-026 Deassertion of the winner's req during BUSY SHALL NOT abort the transaction; ready SHALL still pulse.
REQ-027 Input changes on addr/wd/we during BUSY SHALL NOT affect mem_* outputs.
REQ-028 grant SHALL be one-hot during BUSY and RESP and 2'b00 in IDLE; ready0 and ready1 SHALL never be high together.
REQ-029 LAT=1 SHALL yield one mem_en cycle; counter width SHALL be 4 bits.

Reset
REQ-030 Reset SHALL force IDLE, grant=0, mem_en=0, mem_we=0, mem_addr=0, mem_wd=0, ready0=ready1=0, rd0=rd1=0, counter=0, last=1 (core 0 wins the first tie).
REQ-031 Reset asserted in BUSY or RESP SHALL abort: mem_en and ready low on the next cycle, no ready pulse issued for the aborted access.
REQ-032 Reset SHALL take priority over any simultaneous request.

Verification
REQ-033 LAT=2, req0 read addr=0x40, mem_rd=0xDEADBEEF -> mem_en cycles k+1,k+2, ready0 at k+3, rd0=0xDEADBEEF, grant=01 k+1..k+3.
REQ-034 After reset, req0 and req1 both high held -> core 0 served first, core 1 second, then core 0 (alternation), no cycle with both ready.
REQ-035 req1 write addr=0x80 wd=0x12345678 -> mem_we=1, mem_addr=0x80, mem_wd=0x12345678 for LAT cycles; ready1 pulses; rd1 unchanged.
REQ-036 Reset asserted in second BUSY cycle with LAT=3 -> next cycle mem_en=0, grant=00, no ready pulse; subsequent req1 served normally.
REQ-037 LAT=1, req0 held continuously -> back-to-back accesses every 3 cycles, one ready0 pulse each; addr0 changed mid-BUSY not seen on mem_addr.
